// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 move controller.
package connect4_pkg;

    localparam int COLS = 4;

    typedef logic [1:0] col_t;
    typedef logic [2:0] row_t;

    // 0 = player A, 1 = player B
    typedef logic player_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_VALIDATE = 3'd1,
        S_COMMIT   = 3'd2,
        S_CHECK    = 3'd3,
        S_OVER     = 3'd4
    } move_state_t;

endpackage

// File: rtl/connect4_move_ctrl.sv
// Connect-4 move sequencer: validates a column request against the column
// heights, commits the token to the board and height counter, hands off to
// the win checker and alternates turns. All outputs come from registers or
// are decoded from the state register only.
import connect4_pkg::*;

module connect4_move_ctrl #(
    parameter int ROWS = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_game,
    input  logic       move_req,
    input  logic [1:0] move_col,
    input  logic [2:0] height_0,
    input  logic [2:0] height_1,
    input  logic [2:0] height_2,
    input  logic [2:0] height_3,
    input  logic       check_done,
    input  logic       check_win,
    output logic       add,
    output logic [1:0] counter,
    output logic       counters_clear,
    output logic       board_we,
    output logic [2:0] board_row,
    output logic [1:0] board_col,
    output logic       board_player,
    output logic       check_start,
    output logic       player,
    output logic       busy,
    output logic       move_reject,
    output logic       game_over,
    output logic       winner_valid,
    output logic       winner,
    output logic       draw,
    output logic [5:0] move_count
);

    localparam row_t       ROWS_C  = 3'(ROWS);
    localparam logic [5:0] CELLS_C = 6'(COLS * ROWS);

    move_state_t state_r, state_next_s;
    col_t        col_q_r;
    row_t        row_q_r;
    row_t        height_sel_s;
    player_t     player_r;
    logic [5:0]  move_count_r;
    logic        check_start_r;
    logic        counters_clear_r;
    logic        winner_valid_r;
    logic        winner_r;
    logic        draw_r;

    // Select the height of the requested column.
    always_comb begin
        height_sel_s = 3'd0;
        case (move_col)
            2'd0:    height_sel_s = height_0;
            2'd1:    height_sel_s = height_1;
            2'd2:    height_sel_s = height_2;
            2'd3:    height_sel_s = height_3;
            default: height_sel_s = 3'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a restart overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (new_game) begin
            state_next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (move_req) state_next_s = S_VALIDATE;
                    else          state_next_s = S_IDLE;
                end
                S_VALIDATE: begin
                    if (row_q_r >= ROWS_C) state_next_s = S_IDLE;
                    else                   state_next_s = S_COMMIT;
                end
                S_COMMIT: state_next_s = S_CHECK;
                S_CHECK: begin
                    if (!check_done)                  state_next_s = S_CHECK;
                    else if (check_win)               state_next_s = S_OVER;
                    else if (move_count_r == CELLS_C) state_next_s = S_OVER;
                    else                              state_next_s = S_IDLE;
                end
                S_OVER:  state_next_s = S_OVER;
                default: state_next_s = S_IDLE;
            endcase
        end
    end

    // Move latch, turn, move counter, result flags and one-shot strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q_r          <= 2'd0;
            row_q_r          <= 3'd0;
            player_r         <= 1'b0;
            move_count_r     <= 6'd0;
            check_start_r    <= 1'b0;
            counters_clear_r <= 1'b0;
            winner_valid_r   <= 1'b0;
            winner_r         <= 1'b0;
            draw_r           <= 1'b0;
        end else if (new_game) begin
            player_r         <= 1'b0;
            move_count_r     <= 6'd0;
            check_start_r    <= 1'b0;
            counters_clear_r <= 1'b1;
            winner_valid_r   <= 1'b0;
            winner_r         <= 1'b0;
            draw_r           <= 1'b0;
        end else begin
            counters_clear_r <= 1'b0;
            // high exactly in the first CHECK cycle
            check_start_r    <= (state_r == S_COMMIT);
            case (state_r)
                S_IDLE: begin
                    if (move_req) begin
                        col_q_r <= move_col;
                        row_q_r <= height_sel_s;
                    end
                end
                S_COMMIT: move_count_r <= move_count_r + 6'd1;
                S_CHECK: begin
                    if (check_done) begin
                        if (check_win) begin
                            winner_valid_r <= 1'b1;
                            winner_r       <= player_r;
                        end else if (move_count_r == CELLS_C) begin
                            draw_r <= 1'b1;
                        end else begin
                            player_r <= ~player_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign add            = (state_r == S_COMMIT);
    assign counter        = (state_r == S_COMMIT) ? col_q_r : 2'd0;
    assign board_we       = (state_r == S_COMMIT);
    assign board_row      = (state_r == S_COMMIT) ? row_q_r : 3'd0;
    assign board_col      = (state_r == S_COMMIT) ? col_q_r : 2'd0;
    assign board_player   = (state_r == S_COMMIT) ? player_r : 1'b0;
    assign check_start    = check_start_r;
    assign counters_clear = counters_clear_r;
    assign player         = player_r;
    assign busy           = (state_r != S_IDLE) && (state_r != S_OVER);
    assign move_reject    = (state_r == S_VALIDATE) && (row_q_r >= ROWS_C);
    assign game_over      = (state_r == S_OVER);
    assign winner_valid   = winner_valid_r;
    assign winner         = winner_r;
    assign draw           = draw_r;
    assign move_count     = move_count_r;

endmodule

// File: tb/tb_connect4_move_ctrl.sv
// Self-checking bench for connect4_move_ctrl. The bench plays the role of
// the height counter and win checker; expected board writes are queued when
// a move is requested and compared when the controller writes the board.
module tb_connect4_move_ctrl;

    localparam int ROWS  = 6;
    localparam int CELLS = 4 * ROWS;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       new_game = 1'b0;
    logic       move_req = 1'b0;
    logic [1:0] move_col = 2'd0;
    logic       check_done = 1'b0;
    logic       check_win = 1'b0;
    logic       add, counters_clear, board_we, board_player, check_start;
    logic       player, busy, move_reject, game_over, winner_valid, winner, draw;
    logic [1:0] counter, board_col;
    logic [2:0] board_row;
    logic [5:0] move_count;
    logic [2:0] hgt [4];

    typedef struct {
        logic [1:0] col;
        logic [2:0] row;
        logic       ply;
    } exp_t;
    exp_t sb_q [$];

    int checks = 0;
    int errors = 0;
    int exp_h [4];
    int exp_count = 0;
    bit exp_player = 1'b0;
    bit exp_over = 1'b0;
    bit exp_wv = 1'b0;
    bit exp_winner = 1'b0;
    bit exp_draw = 1'b0;
    bit full_flag;

    connect4_move_ctrl #(.ROWS(ROWS)) dut (
        .clk(clk), .reset_n(reset_n), .new_game(new_game),
        .move_req(move_req), .move_col(move_col),
        .height_0(hgt[0]), .height_1(hgt[1]), .height_2(hgt[2]), .height_3(hgt[3]),
        .check_done(check_done), .check_win(check_win),
        .add(add), .counter(counter), .counters_clear(counters_clear),
        .board_we(board_we), .board_row(board_row), .board_col(board_col),
        .board_player(board_player), .check_start(check_start),
        .player(player), .busy(busy), .move_reject(move_reject),
        .game_over(game_over), .winner_valid(winner_valid), .winner(winner),
        .draw(draw), .move_count(move_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Height counter model: counts on the falling edge inside the add period.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) hgt[i] = 3'd0;
        end else if (counters_clear) begin
            for (int i = 0; i < 4; i++) hgt[i] = 3'd0;
        end else if (add) begin
            hgt[counter] = hgt[counter] + 3'd1;
        end
    end

    // Scoreboard: every board write must match the oldest queued move.
    always @(negedge clk) begin
        if (reset_n && board_we) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_we", 32'(board_we), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("we_col", 32'(board_col), 32'(e.col));
                check_eq("we_row", 32'(board_row), 32'(e.row));
                check_eq("we_player", 32'(board_player), 32'(e.ply));
                check_eq("we_add", 32'(add), 32'd1);
                check_eq("we_counter", 32'(counter), 32'(e.col));
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 4; i++) exp_h[i] = 0;
        exp_count = 0; exp_player = 1'b0; exp_over = 1'b0;
        exp_wv = 1'b0; exp_winner = 1'b0; exp_draw = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_player"}, 32'(player), 32'(exp_player));
        check_eq({tag, "_over"}, 32'(game_over), 32'(exp_over));
        check_eq({tag, "_wv"}, 32'(winner_valid), 32'(exp_wv));
        check_eq({tag, "_winner"}, 32'(winner), 32'(exp_winner));
        check_eq({tag, "_draw"}, 32'(draw), 32'(exp_draw));
        check_eq({tag, "_count"}, 32'(move_count), 32'(exp_count));
    endtask

    // Requests a move; returns at the negedge of the first CHECK cycle,
    // or one cycle after VALIDATE for a rejected move.
    task automatic start_move(input int col, output bit full);
        full = (exp_h[col] >= ROWS);
        @(posedge clk); #1;
        move_req = 1'b1; move_col = 2'(col);
        if (!full) sb_q.push_back('{col: 2'(col), row: 3'(exp_h[col]), ply: exp_player});
        @(posedge clk); #1;
        move_req = 1'b0;
        @(negedge clk);
        check_eq("validate_busy", 32'(busy), 32'd1);
        check_eq("reject", 32'(move_reject), 32'(full));
        check_eq("validate_noadd", 32'(add), 32'd0);
        if (full) begin
            @(negedge clk);
            check_eq("reject_once", 32'(move_reject), 32'd0);
            check_eq("reject_idle", 32'(busy), 32'd0);
            check_eq("reject_noadd", 32'(add), 32'd0);
            return;
        end
        exp_h[col]++;
        @(negedge clk);
        check_eq("commit_add", 32'(add), 32'd1);
        check_eq("commit_nostart", 32'(check_start), 32'd0);
        exp_count++;
        @(negedge clk);
        check_eq("check_start", 32'(check_start), 32'd1);
        check_eq("check_noadd", 32'(add), 32'd0);
        check_eq("check_count", 32'(move_count), 32'(exp_count));
    endtask

    // From the first CHECK cycle: deliver the checker result one cycle later.
    task automatic finish_check(input bit win);
        @(negedge clk);
        check_eq("start_pulse", 32'(check_start), 32'd0);
        check_eq("check_busy", 32'(busy), 32'd1);
        check_done = 1'b1; check_win = win;
        @(posedge clk); #1;
        check_done = 1'b0; check_win = 1'b0;
        if (win) begin
            exp_over = 1'b1; exp_wv = 1'b1; exp_winner = exp_player;
        end else if (exp_count == CELLS) begin
            exp_over = 1'b1; exp_draw = 1'b1;
        end else begin
            exp_player = ~exp_player;
        end
        @(negedge clk);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_status("done");
    endtask

    task automatic play(input int col, input bit win);
        bit full;
        start_move(col, full);
        if (!full) finish_check(win);
    endtask

    task automatic restart();
        @(posedge clk); #1;
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        clear_model();
        @(negedge clk);
        check_eq("restart_clear", 32'(counters_clear), 32'd1);
        check_eq("restart_busy", 32'(busy), 32'd0);
        check_status("restart");
        @(negedge clk);
        check_eq("restart_clear_once", 32'(counters_clear), 32'd0);
    endtask

    initial begin
        clear_model();
        // Reset state
        #3;
        check_eq("rst_add", 32'(add), 32'd0);
        check_eq("rst_clear", 32'(counters_clear), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_start", 32'(check_start), 32'd0);
        check_status("rst");
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Basic move in column 2
        play(2, 1'b0);

        // Fill column 1, then a move into the full column is rejected
        for (int i = 0; i < ROWS; i++) play(1, 1'b0);
        start_move(1, full_flag);
        check_eq("full_flag", 32'(full_flag), 32'd1);
        check_status("after_reject");

        // Player B wins
        check_eq("b_turn", 32'(player), 32'd1);
        play(0, 1'b1);
        // Requests in OVER are ignored
        @(posedge clk); #1; move_req = 1'b1; move_col = 2'd3;
        @(posedge clk); #1; move_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("over_noadd", 32'(add), 32'd0);
            check_eq("over_noreject", 32'(move_reject), 32'd0);
            check_status("over");
        end

        // Restart; a request during CHECK is dropped
        restart();
        start_move(3, full_flag);
        move_req = 1'b1; move_col = 2'd0;
        @(posedge clk); #1; move_req = 1'b0;
        finish_check(1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("dropped_noadd", 32'(add), 32'd0);
            check_eq("dropped_idle", 32'(busy), 32'd0);
        end

        // new_game together with move_req while in CHECK
        start_move(3, full_flag);
        new_game = 1'b1; move_req = 1'b1; move_col = 2'd2;
        @(posedge clk); #1;
        new_game = 1'b0; move_req = 1'b0;
        clear_model();
        @(negedge clk);
        check_eq("coll_clear", 32'(counters_clear), 32'd1);
        check_eq("coll_busy", 32'(busy), 32'd0);
        check_status("coll");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("coll_noadd", 32'(add), 32'd0);
            check_eq("coll_clear_once", 32'(counters_clear), 32'd0);
            check_eq("coll_idle", 32'(busy), 32'd0);
        end

        // Draw: fill every cell with the checker never reporting a win
        for (int i = 0; i < CELLS; i++) play(i % 4, 1'b0);
        check_eq("draw_flag", 32'(draw), 32'd1);
        check_eq("draw_over", 32'(game_over), 32'd1);
        check_eq("draw_count", 32'(move_count), 32'(CELLS));

        // Asynchronous reset in the middle of COMMIT
        restart();
        @(posedge clk); #1; move_req = 1'b1; move_col = 2'd3;
        sb_q.push_back('{col: 2'd3, row: 3'd0, ply: 1'b0});
        @(posedge clk); #1; move_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_add", 32'(add), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_add", 32'(add), 32'd0);
        check_eq("async_we", 32'(board_we), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_count", 32'(move_count), 32'd0);
        check_eq("async_player", 32'(player), 32'd0);
        clear_model();
        @(negedge clk);
        reset_n = 1'b1;
        play(3, 1'b0);

        repeat (2) @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
